pp_accumulator: RTL and testbench
=================================

Name: pp_accumulator

Overview:
- Sequential consumer of the partial-product generator output: accepts one full set of N pre-shifted 2N-bit partial-product rows and reduces them to the final 2N-bit product.
- Uses K rows per cycle through a carry-save chain, then one final carry-propagate add.
- Sits between the partial-product generator and the multiplier result port.
- Gives a low-area, multi-cycle alternative to the combinational Wallace tree, using a valid/ready handshake on both sides.

Parameters:
- N, 16, operand width; number of partial-product rows; row width is 2N.
- K, 4, rows folded per REDUCE cycle; N % K == 0 and K >= 1 required (elaboration error otherwise).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  PP set valid.
- in_ready  output  1  block can accept a PP set.
- in_pp  input  [N] x 2N  unpacked array of partial-product rows, index 0 = LSB row, already shifted.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream accepts product.
- out_product  output  2N  sum of all rows mod 2^2N.

Behaviour:
- One clock; reset is asynchronous and active-high. Asserting rst immediately forces:
  - state=IDLE;
  - pp_reg, sum, carry, idx, out_product all 0;
  - out_valid=0, in_ready=0 while rst is high.
- FSM states: IDLE, REDUCE, FINAL, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready: capture in_pp into pp_reg, clear sum/carry, set idx=0, go to REDUCE.
  - in_pp is sampled only at this edge; later changes are ignored.
- REDUCE: in_ready=0.
  - Each cycle, feed rows pp_reg[idx .. idx+K-1] through K chained 3:2 CSAs into (sum, carry).
  - idx += K.
  - When idx+K == N, go to FINAL after this fold. This takes exactly N/K cycles (4 at defaults).
- FINAL: register out_product = sum + carry, truncated to 2N bits; go to DONE.
- DONE: out_valid=1; out_product held stable.
  - On out_ready go to IDLE, with out_valid=0 the next cycle.
  - out_ready low: hold indefinitely; no new input accepted.
- Latency: acceptance edge E0 -> out_valid high after edge E0+N/K+1 (E5 at defaults). Minimum initiation interval is N/K+3 cycles.
- Arithmetic:
  - All rows are treated as unsigned 2N-bit values.
  - CSA carry is shifted left by 1 with its MSB discarded; result is exact mod 2^2N. Overflow silently wraps with no flag.
- out_valid=1 and out_ready=1 in the same cycle DONE is entered: the product is transferred on that edge.
- in_valid while busy: ignored; the sender must hold it, per valid/ready rules.
- Reset mid-REDUCE or mid-DONE: the partial result is discarded and no out_valid is produced for that set.

Decomposition:
- Package pp_pkg:
  - localparam defaults N_DEF=16, K_DEF=4;
  - typedef enum logic [1:0] {IDLE, REDUCE, FINAL, DONE} acc_state_t;
  - function-friendly typedef for a 2N-bit row (pp_row_t).
- One sub-module: csa_3to2, parameterised width W.
  - Inputs a, b, c; outputs sum = a^b^c and carry = majority << 1, truncated to W.
  - Instantiated K times in a chain inside pp_accumulator.

Test Plan:
- Rows of PPG(X=0x0007, Y=0x0003): handshake, then out_valid 5 cycles later with out_product=0x00000015; in_ready=0 throughout.
- Rows of PPG(X=0xFFFF, Y=0x0003) -> out_product=0x0002FFFD. Rows of PPG(X=0xF00F, Y=0xFFFF) -> 0xF00E0FF1.
- All 16 rows = 0xFFFFFFFF -> out_product=0xFFFFFFF0 (wrap-around check).
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and out_product stable, in_ready=0; pulse out_ready -> next cycle out_valid=0, in_ready=1.
- Async reset asserted mid-REDUCE (after 2 folds), between clock edges -> outputs 0 immediately. After release: in_ready=1 and no stale out_valid. A fresh set of X=3, Y=5 rows then yields out_product=0x0000000F.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared types and defaults for the sequential partial-product accumulator.
// Provides the FSM state enum, default sizes and a default-width row type.
package pp_pkg;

   localparam int N_DEF = 16;
   localparam int K_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      REDUCE,
      FINAL,
      DONE
   } acc_state_t;

   typedef logic [2*N_DEF-1:0] pp_row_t;

endpackage

// File: rtl/csa_3to2.sv
// 3:2 carry-save adder over W-bit words.
// Ports: a, b, c in; sum = a^b^c; carry = majority(a,b,c) << 1, truncated to W.
module csa_3to2 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] c,
   output logic [W-1:0] sum,
   output logic [W-1:0] carry
);

   logic [W-1:0] maj;

   assign maj   = (a & b) | (a & c) | (b & c);
   assign sum   = a ^ b ^ c;
   // Carry weight is one bit up; the MSB carry falls off (mod 2^W).
   assign carry = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/pp_accumulator.sv
// Multi-cycle reducer of N pre-shifted 2N-bit partial-product rows to one product.
// Ports: clk, rst (async high), in_valid/in_ready/in_pp, out_valid/out_ready/out_product.
module pp_accumulator
   import pp_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int K = K_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] in_pp [N],
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] out_product
);

   localparam int W  = 2 * N;
   localparam int G  = N / K;
   localparam int GW = (G > 1) ? $clog2(G) : 1;
   localparam logic [GW-1:0] LAST = GW'(G - 1);

   if (K < 1) begin : g_bad_k
      $error("pp_accumulator: K must be >= 1");
   end else if (N % K != 0) begin : g_bad_nk
      $error("pp_accumulator: N must be a multiple of K");
   end

   acc_state_t     state, state_nx;
   logic [W-1:0]   pp_reg [N];
   logic [W-1:0]   sum, carry;
   // Fold-group counter: row index idx = grp*K.
   logic [GW-1:0]  grp;

   logic [W-1:0]   row [K];
   logic [W-1:0]   cs  [K+1];
   logic [W-1:0]   cc  [K+1];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (in_valid)    state_nx = REDUCE;
         REDUCE: if (grp == LAST) state_nx = FINAL;
         FINAL:                   state_nx = DONE;
         DONE:   if (out_ready)   state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
   end

   // Select the K rows of the current fold group with constant indices only.
   always_comb begin
      for (int j = 0; j < K; j++) begin
         row[j] = pp_reg[j];
         for (int g = 0; g < G; g++) begin
            if (grp == GW'(g)) row[j] = pp_reg[g*K + j];
         end
      end
   end

   assign cs[0] = sum;
   assign cc[0] = carry;

   for (genvar j = 0; j < K; j++) begin : g_csa
      csa_3to2 #(.W(W)) u_csa (
         .a     (cs[j]),
         .b     (cc[j]),
         .c     (row[j]),
         .sum   (cs[j+1]),
         .carry (cc[j+1])
      );
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) pp_reg[i] <= '0;
         sum         <= '0;
         carry       <= '0;
         grp         <= '0;
         out_product <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int i = 0; i < N; i++) pp_reg[i] <= in_pp[i];
                  sum   <= '0;
                  carry <= '0;
                  grp   <= '0;
               end
            end
            REDUCE: begin
               sum   <= cs[K];
               carry <= cc[K];
               grp   <= grp + 1'b1;
            end
            FINAL: out_product <= sum + carry;
            DONE:  ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pp_accumulator.sv
// Directed self-checking bench for pp_accumulator at N=16, K=4.
// Drives PPG-style row sets and checks handshake timing and products.
module tb_pp_accumulator;

   localparam int N = 16;
   localparam int K = 4;
   localparam int W = 2 * N;
   localparam int L = N / K;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] pp [N];
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_product;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pp_accumulator #(.N(N), .K(K)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pp       (pp),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product)
   );

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic mk(input logic [15:0] x, input logic [15:0] y);
      for (int i = 0; i < N; i++)
         pp[i] = y[i] ? (W'(x) << i) : '0;
   endtask

   task automatic fill(input logic [W-1:0] v);
      for (int i = 0; i < N; i++) pp[i] = v;
   endtask

   // Wait (bounded) for in_ready, present the set for one edge, then scramble.
   task automatic accept(input string tag);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_rdy"}, W'(in_ready), 1);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      fill(32'hDEAD_BEEF);
   endtask

   // Busy for N/K+1 cycles, then product valid.
   task automatic pipe(input string tag, input logic [W-1:0] exp);
      for (int c = 0; c <= L; c++) begin
         @(negedge clk);
         chk({tag, "_busy_rdy"}, W'(in_ready), 0);
         chk({tag, "_busy_ov"}, W'(out_valid), 0);
      end
      @(negedge clk);
      chk({tag, "_ov"}, W'(out_valid), 1);
      chk({tag, "_rdy"}, W'(in_ready), 0);
      chk({tag, "_prod"}, out_product, exp);
   endtask

   task automatic drain(input string tag);
      @(negedge clk);
      chk({tag, "_ov_clr"}, W'(out_valid), 0);
      chk({tag, "_rdy_back"}, W'(in_ready), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fill('0);
      #2;
      chk("rst_rdy", W'(in_ready), 0);
      chk("rst_ov", W'(out_valid), 0);
      chk("rst_prod", out_product, 0);
      #20 rst = 1'b0;

      mk(16'h0007, 16'h0003);
      accept("t1");
      pipe("t1", 32'h0000_0015);
      drain("t1");

      mk(16'hFFFF, 16'h0003);
      accept("t2");
      pipe("t2", 32'h0002_FFFD);
      drain("t2");

      mk(16'hF00F, 16'hFFFF);
      accept("t3");
      pipe("t3", 32'hF00E_0FF1);
      drain("t3");

      fill(32'hFFFF_FFFF);
      accept("wrap");
      pipe("wrap", 32'hFFFF_FFF0);
      drain("wrap");

      out_ready = 1'b0;
      mk(16'h1234, 16'h0010);
      accept("bp");
      pipe("bp", 32'h0001_2340);
      mk(16'h0001, 16'h0001);
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_ov", W'(out_valid), 1);
         chk("bp_hold_prod", out_product, 32'h0001_2340);
         chk("bp_hold_rdy", W'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("bp");

      mk(16'hABCD, 16'h00FF);
      accept("ar");
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("ar_ov", W'(out_valid), 0);
      chk("ar_rdy", W'(in_ready), 0);
      chk("ar_prod", out_product, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("ar_post_rdy", W'(in_ready), 1);
         chk("ar_post_ov", W'(out_valid), 0);
      end

      mk(16'h0003, 16'h0005);
      accept("t5");
      pipe("t5", 32'h0000_000F);
      drain("t5");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
